// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared types for the decode slot and interlock control.
package cpu_pipe_pkg;
  typedef enum logic {RUN, STALL} state_t;
  function automatic int addr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  localparam int NUM_REGS = 32;
  localparam int AW = addr_w(NUM_REGS);
  typedef struct packed {
    logic [AW-1:0] rnum1;
    logic [AW-1:0] rnum2;
    logic [AW-1:0] wnum;
    logic use1;
    logic use2;
    logic we;
  } slot_t;
endpackage

// File: rtl/register.sv
// register: plain loadable register with async active-low reset to zero.
module register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = load ? d : q_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/stall_counter.sv
// stall_counter: bubble countdown with load, decrement, clear and zero flag.
module stall_counter #(
  parameter int STALL_CYCLES = 2,
  localparam int W = $clog2(STALL_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = clr ? '0 :
            load ? W'(STALL_CYCLES - 1) :
            (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: decode slot that holds an instruction and injects bubbles on RAW hazards.
module hazard_stall_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH = NUM_REGS,
  parameter int STALL_CYCLES = 2,
  parameter int PERF_W = 16,
  localparam int ADDR_WIDTH = addr_w(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_rnum1,
  input  logic [ADDR_WIDTH-1:0] if_rnum2,
  input  logic [ADDR_WIDTH-1:0] if_wnum,
  input  logic                  if_use1,
  input  logic                  if_use2,
  input  logic                  if_we,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] hz_rnum1,
  output logic [ADDR_WIDTH-1:0] hz_rnum2,
  output logic [ADDR_WIDTH-1:0] hz_wnum,
  output logic                  hz_is_write_reg,
  output logic                  is_nop,
  input  logic                  is_full_rnum1,
  input  logic                  is_full_rnum2,
  output logic                  ex_valid,
  output logic [ADDR_WIDTH-1:0] ex_rnum1,
  output logic [ADDR_WIDTH-1:0] ex_rnum2,
  output logic [ADDR_WIDTH-1:0] ex_wnum,
  output logic                  ex_we,
  output logic [PERF_W-1:0]     stall_count
);
  localparam int EXW = 3 * ADDR_WIDTH + 2;
  state_t state_q, state_d;
  logic slot_v_q, slot_v_d;
  slot_t slot_q, slot_d;
  logic [PERF_W-1:0] stall_count_q, stall_count_d;
  logic [EXW-1:0] ex_q, ex_d;
  logic in_run, hazard, issue, bump, cnt_zero;
  always_comb begin
    in_run = (state_q == RUN);
    hazard = slot_v_q & ((slot_q.use1 & is_full_rnum1) | (slot_q.use2 & is_full_rnum2));
    issue = !flush & (in_run ? slot_v_q & !hazard : cnt_zero);
    bump = !flush & (in_run ? hazard : !cnt_zero);
    if_ready = flush | (in_run ? !hazard : cnt_zero);
    is_nop = !issue;
    state_d = (flush || (!in_run && cnt_zero)) ? RUN : (in_run && hazard) ? STALL : state_q;
    slot_v_d = flush ? 1'b0 : if_ready ? if_valid : slot_v_q;
    slot_d = (!flush && if_ready && if_valid) ?
             slot_t'{rnum1: if_rnum1, rnum2: if_rnum2, wnum: if_wnum,
                     use1: if_use1, use2: if_use2, we: if_we} : slot_q;
    stall_count_d = (bump && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
    ex_d = {issue, issue ? {slot_q.rnum1, slot_q.rnum2, slot_q.wnum, slot_q.we} : ex_q[EXW-2:0]};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= RUN;
      slot_v_q <= 1'b0;
      slot_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      slot_v_q <= slot_v_d;
      slot_q <= slot_d;
      stall_count_q <= stall_count_d;
    end
  stall_counter #(.STALL_CYCLES(STALL_CYCLES)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .load(!flush && in_run && hazard),
    .dec(!flush && !in_run && !cnt_zero),
    .zero(cnt_zero)
  );
  register #(.W(EXW)) u_ex (
    .clk(clk),
    .rst(rst),
    .load(1'b1),
    .d(ex_d),
    .q(ex_q)
  );
  assign {ex_valid, ex_rnum1, ex_rnum2, ex_wnum, ex_we} = ex_q;
  assign hz_rnum1 = slot_q.rnum1;
  assign hz_rnum2 = slot_q.rnum2;
  assign hz_wnum = slot_q.wnum;
  assign hz_is_write_reg = slot_q.we;
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors for the decode slot interlock.
module tb_hazard_stall_ctrl;
  logic clk = 0, rst = 0;
  logic if_valid = 0, if_use1 = 0, if_use2 = 0, if_we = 0, flush = 0;
  logic [4:0] if_rnum1 = 0, if_rnum2 = 0, if_wnum = 0;
  logic is_full_rnum1 = 0, is_full_rnum2 = 0;
  logic if_ready, is_nop, hz_is_write_reg, ex_valid, ex_we;
  logic [4:0] hz_rnum1, hz_rnum2, hz_wnum, ex_rnum1, ex_rnum2, ex_wnum;
  logic [15:0] stall_count;
  logic s_if_ready, s_is_nop, s_hz_we, s_ex_valid, s_ex_we;
  logic [4:0] s_hz_r1, s_hz_r2, s_hz_w, s_ex_r1, s_ex_r2, s_ex_w;
  logic [1:0] s_stall_count;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_rnum1(if_rnum1), .if_rnum2(if_rnum2), .if_wnum(if_wnum),
    .if_use1(if_use1), .if_use2(if_use2), .if_we(if_we), .flush(flush),
    .hz_rnum1(hz_rnum1), .hz_rnum2(hz_rnum2), .hz_wnum(hz_wnum),
    .hz_is_write_reg(hz_is_write_reg), .is_nop(is_nop),
    .is_full_rnum1(is_full_rnum1), .is_full_rnum2(is_full_rnum2),
    .ex_valid(ex_valid), .ex_rnum1(ex_rnum1), .ex_rnum2(ex_rnum2),
    .ex_wnum(ex_wnum), .ex_we(ex_we), .stall_count(stall_count)
  );

  hazard_stall_ctrl #(.PERF_W(2)) dut_sat (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(s_if_ready),
    .if_rnum1(if_rnum1), .if_rnum2(if_rnum2), .if_wnum(if_wnum),
    .if_use1(if_use1), .if_use2(if_use2), .if_we(if_we), .flush(flush),
    .hz_rnum1(s_hz_r1), .hz_rnum2(s_hz_r2), .hz_wnum(s_hz_w),
    .hz_is_write_reg(s_hz_we), .is_nop(s_is_nop),
    .is_full_rnum1(is_full_rnum1), .is_full_rnum2(is_full_rnum2),
    .ex_valid(s_ex_valid), .ex_rnum1(s_ex_r1), .ex_rnum2(s_ex_r2),
    .ex_wnum(s_ex_w), .ex_we(s_ex_we), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int r1, input int r2, input int w,
                       input logic u1, input logic u2, input logic we);
    if_valid = v;
    if_rnum1 = 5'(r1);
    if_rnum2 = 5'(r2);
    if_wnum = 5'(w);
    if_use1 = u1;
    if_use2 = u2;
    if_we = we;
  endtask

  initial begin
    #3;
    chk("rst_if_ready", 32'(if_ready), 1);
    chk("rst_is_nop", 32'(is_nop), 1);
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_stall_count", 32'(stall_count), 0);
    #9 rst = 1;
    tick;
    // back-to-back independent instructions
    drive(1, 2, 0, 1, 1, 0, 1);
    #2;
    chk("b2b_empty_nop", 32'(is_nop), 1);
    chk("b2b_empty_ready", 32'(if_ready), 1);
    tick;
    drive(1, 4, 0, 3, 1, 0, 1);
    #2;
    chk("b2b_i1_issue", 32'(is_nop), 0);
    chk("b2b_i1_ready", 32'(if_ready), 1);
    chk("b2b_hz_rnum1", 32'(hz_rnum1), 2);
    chk("b2b_hz_wnum", 32'(hz_wnum), 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("b2b_ex1_valid", 32'(ex_valid), 1);
    chk("b2b_ex1_wnum", 32'(ex_wnum), 1);
    chk("b2b_ex1_rnum1", 32'(ex_rnum1), 2);
    chk("b2b_i2_issue", 32'(is_nop), 0);
    chk("b2b_hz_rnum1_i2", 32'(hz_rnum1), 4);
    tick;
    #2;
    chk("b2b_ex2_valid", 32'(ex_valid), 1);
    chk("b2b_ex2_wnum", 32'(ex_wnum), 3);
    chk("b2b_drained_nop", 32'(is_nop), 1);
    tick;
    #2;
    chk("b2b_ex_idle", 32'(ex_valid), 0);
    chk("b2b_ex_hold_wnum", 32'(ex_wnum), 3);
    chk("b2b_no_stall", 32'(stall_count), 0);
    // RAW hazard on source 1, two bubbles
    drive(1, 1, 0, 5, 1, 0, 1);
    tick;
    drive(1, 6, 0, 7, 1, 0, 1);
    is_full_rnum1 = 1;
    #2;
    chk("hz_detect_nop", 32'(is_nop), 1);
    chk("hz_detect_ready", 32'(if_ready), 0);
    tick;
    #2;
    chk("hz_b2_nop", 32'(is_nop), 1);
    chk("hz_b2_ready", 32'(if_ready), 0);
    chk("hz_b2_ex_valid", 32'(ex_valid), 0);
    chk("hz_b2_count", 32'(stall_count), 1);
    tick;
    is_full_rnum1 = 0;
    #2;
    chk("hz_issue_nop", 32'(is_nop), 0);
    chk("hz_issue_ready", 32'(if_ready), 1);
    chk("hz_issue_wnum", 32'(hz_wnum), 5);
    chk("hz_count", 32'(stall_count), 2);
    chk("hz_sat_count", 32'(s_stall_count), 2);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("hz_ex_valid", 32'(ex_valid), 1);
    chk("hz_ex_wnum", 32'(ex_wnum), 5);
    chk("hz_next_issue", 32'(is_nop), 0);
    chk("hz_next_hz_wnum", 32'(hz_wnum), 7);
    tick;
    #2;
    chk("hz_ex_wnum_i4", 32'(ex_wnum), 7);
    // hazard flag on an unused source
    drive(1, 8, 9, 10, 1, 0, 1);
    is_full_rnum2 = 1;
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("unused_no_stall_nop", 32'(is_nop), 0);
    chk("unused_ready", 32'(if_ready), 1);
    tick;
    is_full_rnum2 = 0;
    #2;
    chk("unused_ex_wnum", 32'(ex_wnum), 10);
    chk("unused_count", 32'(stall_count), 2);
    // flush while stalled with cnt=1
    drive(1, 3, 0, 11, 1, 0, 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    is_full_rnum1 = 1;
    tick;
    flush = 1;
    drive(1, 2, 0, 14, 1, 0, 1);
    #2;
    chk("flush_ready", 32'(if_ready), 1);
    chk("flush_nop", 32'(is_nop), 1);
    tick;
    flush = 0;
    is_full_rnum1 = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("flush_slot_empty", 32'(is_nop), 1);
    chk("flush_run_ready", 32'(if_ready), 1);
    chk("flush_ex_valid", 32'(ex_valid), 0);
    chk("flush_count", 32'(stall_count), 3);
    tick;
    #2;
    chk("flush_never_issued", 32'(ex_valid), 0);
    // second hazard on source 2 drives the 2-bit counter into saturation
    drive(1, 0, 4, 12, 0, 1, 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    is_full_rnum2 = 1;
    tick;
    tick;
    is_full_rnum2 = 0;
    #2;
    chk("sat_issue", 32'(is_nop), 0);
    tick;
    #2;
    chk("sat_ex_wnum", 32'(ex_wnum), 12);
    chk("sat_main_count", 32'(stall_count), 5);
    chk("sat_small_count", 32'(s_stall_count), 3);
    // asynchronous reset mid-stall
    drive(1, 1, 0, 13, 1, 0, 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    is_full_rnum1 = 1;
    tick;
    #1 rst = 0;
    #1;
    chk("arst_ready", 32'(if_ready), 1);
    chk("arst_nop", 32'(is_nop), 1);
    chk("arst_ex_valid", 32'(ex_valid), 0);
    chk("arst_ex_wnum", 32'(ex_wnum), 0);
    chk("arst_count", 32'(stall_count), 0);
    chk("arst_small_count", 32'(s_stall_count), 0);
    is_full_rnum1 = 0;
    rst = 1;
    tick;
    #2;
    chk("arst_after_ready", 32'(if_ready), 1);
    chk("arst_after_nop", 32'(is_nop), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Decode-slot and interlock controller sitting between instruction fetch and execute, directly in front of the register hazard tracker. Holds one decoded instruction, presents its source/destination register numbers to the tracker, and consumes the tracker's `is_full_rnum1`/`is_full_rnum2` flags. On a read-after-write hazard it freezes fetch and injects a fixed number of bubbles (driving `is_nop`) before issuing the held instruction into the execute pipeline register.

## Interface
- `WIDTH`, 32, number of architectural registers; `ADDR_WIDTH = $clog2(WIDTH)`
- `STALL_CYCLES`, 2, bubbles per detected hazard (writeback distance); legal range 1..15
- `PERF_W`, 16, width of the stall performance counter
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_valid`  in  1  fetch presents a decoded instruction
- `if_ready`  out  1  slot can accept this cycle
- `if_rnum1`, `if_rnum2`, `if_wnum`  in  ADDR_WIDTH  decoded source/destination numbers
- `if_use1`, `if_use2`, `if_we`  in  1  source 1/2 used; writes a register
- `flush`  in  1  synchronous kill of slot and stall
- `hz_rnum1`, `hz_rnum2`, `hz_wnum`  out  ADDR_WIDTH  slot fields to tracker (combinational from slot)
- `hz_is_write_reg`  out  1  slot `we` to tracker
- `is_nop`  out  1  1 = no instruction issued this cycle (tracker must not load `hz_wnum`)
- `is_full_rnum1`, `is_full_rnum2`  in  1  tracker hazard flags for `hz_rnum1`/`hz_rnum2`
- `ex_valid`  out  1  execute register holds a real instruction
- `ex_rnum1`, `ex_rnum2`, `ex_wnum`  out  ADDR_WIDTH  registered issued fields
- `ex_we`  out  1  registered issued write enable
- `stall_count`  out  PERF_W  saturating count of bubble cycles caused by hazards

## Operation
- States: RUN, STALL. Slot = `slot_valid` + captured fields.
- `hazard = slot_valid & ((if_use1_s & is_full_rnum1) | (if_use2_s & is_full_rnum2))` using slot copies of use bits.
- RUN, slot empty: `is_nop=1`; `if_ready=1`.
- RUN, slot valid, no hazard: issue (`is_nop=0`, ex register loads slot); `if_ready=1` so slot refills same edge.
- RUN, hazard: `is_nop=1`, `if_ready=0`, go STALL with `cnt = STALL_CYCLES-1`; `stall_count++`.
- STALL, `cnt != 0`: `is_nop=1`, `if_ready=0`, `cnt--`, `stall_count++`; hazard flags ignored.
- STALL, `cnt == 0`: issue unconditionally, `if_ready=1`, return RUN.
- Issue with `if_valid=0`: slot becomes empty. Non-issue cycle: ex register loads `ex_valid=0`, fields hold.
- `flush` (highest priority): next edge `slot_valid=0`, `ex_valid=0`, state RUN, `cnt=0`; `if_ready` and `is_nop` forced 1 that cycle; incoming instruction dropped. `stall_count` unaffected.
- `stall_count` saturates at all-ones; no wrap.
- `hz_*` always reflect slot contents, even when empty (don't-care for tracker because `is_nop=1`).

## Timing
- Reset values: state RUN, `slot_valid=0`, `cnt=0`, `ex_valid=0`, `ex_*` fields 0, `stall_count=0`; hence `if_ready=1`, `is_nop=1`.
- Fetch-to-slot 1 cycle; slot-to-`ex_valid` 1 cycle with no hazard.
- Hazard: exactly `STALL_CYCLES` bubble cycles between detection and issue; issue lands `STALL_CYCLES+1` edges after the slot filled.
- `if_ready`, `is_nop`, `hz_*` combinational from state/slot/hazard inputs; no combinational path from `if_*` to `if_ready`.
- Reset assertion mid-stall returns all state to reset values immediately (async).

## Structure
- Shared package `cpu_pipe_pkg`: state enum {RUN, STALL}, `ADDR_WIDTH` helper, slot field struct (rnum1, rnum2, wnum, use1, use2, we).
- One sub-module: `stall_counter` (load / decrement / zero flag, width `$clog2(STALL_CYCLES+1)`). Ex register uses existing `register` block with `load=1`.

## Test plan
- Reset: `rst=0` -> `if_ready=1`, `is_nop=1`, `ex_valid=0`, `stall_count=0`.
- Back-to-back independent instrs (r1<-r2, r3<-r4), flags 0 -> `ex_valid=1` on consecutive cycles, no bubbles, `is_nop` low 2 cycles.
- Hazard, `STALL_CYCLES=2`: slot reads r1 with `is_full_rnum1=1` -> 2 cycles `is_nop=1`, `if_ready=0`, issue on 3rd, `stall_count=2`.
- Hazard flag on unused source (`if_use2=0`, `is_full_rnum2=1`) -> no stall.
- `flush` during STALL (`cnt=1`) -> next cycle RUN, `slot_valid=0`, `ex_valid=0`; held instr never issues.
- `PERF_W=2`, force 5 hazard bubbles -> `stall_count` stays 3.
